// File: rtl/seq_mul_pm_if.sv
// Operand/result bundle for seq_mul_pm: start/sgn/x/y in, p/busy/done out.
// master drives the request side, slave is the multiplier.
interface seq_mul_pm_if #(
  parameter int XW = 4,
  parameter int YW = 3
);
  logic             start;
  logic             sgn;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [XW+YW-1:0] p;
  logic             busy;
  logic             done;

  modport master (output start, sgn, x, y, input p, busy, done);
  modport slave  (input start, sgn, x, y, output p, busy, done);
endinterface

// File: rtl/seq_mul_pm.sv
// Sequential shift-add multiplier, unsigned or two's complement; result YW+1 edges after start.
// No backpressure: start is only sampled while idle, requests during busy are dropped.
module seq_mul_pm #(
  parameter int XW = 4,
  parameter int YW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mul_pm_if.slave  bus
);
  localparam int PW = XW + YW;
  localparam int CW = $clog2(YW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   xm_q, xm_d;
  logic [YW-1:0]   ym_q, ym_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [PW-1:0]   addend;

  always_comb begin
    state_d = state_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    addend  = PW'(xm_q) << cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // XW-bit negate of the most-negative value yields its magnitude as unsigned
          xm_d    = (bus.sgn && bus.x[XW-1]) ? -bus.x : bus.x;
          ym_d    = (bus.sgn && bus.y[YW-1]) ? -bus.y : bus.y;
          neg_d   = bus.sgn & (bus.x[XW-1] ^ bus.y[YW-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (ym_q[0]) acc_d = acc_q + addend;
        ym_d  = ym_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(YW - 1)) state_d = FIN;
      end
      FIN: begin
        p_d     = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xm_q    <= '0;
      ym_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.p    = p_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_mul_pm.sv
// Randomised and directed bench for seq_mul_pm at 4x3 and 8x8 against an integer product model.
module tb_seq_mul_pm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_mul_pm_if #(.XW(4), .YW(3)) a ();
  seq_mul_pm_if #(.XW(8), .YW(8)) b ();

  seq_mul_pm #(.XW(4), .YW(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  seq_mul_pm #(.XW(8), .YW(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Mathematical product of the interpreted operands, wrapped to xw+yw bits.
  function automatic logic [63:0] ref_mul(input int xw, input int yw, input bit s,
                                          input longint x, input longint y);
    longint xv, yv, pr;
    xv = x;
    yv = y;
    if (s && x >= (longint'(1) << (xw - 1))) xv = x - (longint'(1) << xw);
    if (s && y >= (longint'(1) << (yw - 1))) yv = y - (longint'(1) << yw);
    pr = xv * yv;
    return 64'(pr & ((longint'(1) << (xw + yw)) - 1));
  endfunction

  task automatic op_a(input bit s, input int xv, input int yv, input bit full);
    int cyc;
    bit seen;
    logic [63:0] expv;
    expv = ref_mul(4, 3, s, longint'(xv), longint'(yv));
    @(negedge clk);
    a.start = 1'b1; a.sgn = s; a.x = 4'(xv); a.y = 3'(yv);
    @(posedge clk); #1;
    if (full) chk("a_busy_rise", 64'(a.busy), 64'd1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      a.start = 1'b0; a.sgn = 1'($urandom); a.x = 4'($urandom); a.y = 3'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (a.done) seen = 1;
      else if (full) chk("a_busy_mid", 64'(a.busy), 64'd1);
    end
    chk("a_done_seen", 64'(seen), 64'd1);
    chk("a_p", 64'(a.p), expv);
    if (full) begin
      chk("a_latency", 64'(cyc), 64'd4);
      chk("a_busy_fall", 64'(a.busy), 64'd0);
      @(posedge clk); #1;
      chk("a_done_pulse", 64'(a.done), 64'd0);
      chk("a_p_hold", 64'(a.p), expv);
    end
  endtask

  task automatic op_b(input bit s, input int xv, input int yv);
    int cyc;
    bit seen;
    logic [63:0] expv;
    expv = ref_mul(8, 8, s, longint'(xv), longint'(yv));
    @(negedge clk);
    b.start = 1'b1; b.sgn = s; b.x = 8'(xv); b.y = 8'(yv);
    @(posedge clk); #1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      b.start = 1'b0; b.x = 8'($urandom); b.y = 8'($urandom); b.sgn = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (b.done) seen = 1;
    end
    chk("b_done_seen", 64'(seen), 64'd1);
    chk("b_latency", 64'(cyc), 64'd9);
    chk("b_p", 64'(b.p), expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    int last_k;
    a.start = 0; a.sgn = 0; a.x = '0; a.y = '0;
    b.start = 0; b.sgn = 0; b.x = '0; b.y = '0;
    #1;
    chk("rst_a_p", 64'(a.p), 64'd0);
    chk("rst_a_busy", 64'(a.busy), 64'd0);
    chk("rst_a_done", 64'(a.done), 64'd0);
    chk("rst_b_p", 64'(b.p), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    op_a(0, 15, 7, 1);
    chk("t1_105", 64'(a.p), 64'd105);
    op_a(1, 8, 4, 1);
    chk("t2_p32", 64'(a.p), 64'h20);
    op_a(1, 15, 3, 1);
    chk("t2_m3", 64'(a.p), 64'h7D);
    op_a(1, 5, 7, 1);
    chk("t2_m5", 64'(a.p), 64'h7B);
    op_a(0, 0, 5, 1);
    op_a(0, 11, 5, 1);
    chk("t3_55", 64'(a.p), 64'd55);

    // start pulse while busy must be ignored
    @(negedge clk);
    a.start = 1; a.sgn = 0; a.x = 4'd3; a.y = 3'd5;
    @(negedge clk); a.start = 0;
    @(negedge clk); a.start = 1; a.sgn = 1; a.x = 4'd15; a.y = 3'd7;
    @(negedge clk); a.start = 0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (a.done) begin
        dones++;
        chk("t4_p", 64'(a.p), 64'd15);
      end
    end
    chk("t4_dones", 64'(dones), 64'd1);

    // start held high: one operation per YW+2 cycles
    @(negedge clk);
    a.start = 1; a.sgn = 0; a.x = 4'd7; a.y = 3'd3;
    dones = 0; last_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (a.done) begin
        chk("t5_p", 64'(a.p), 64'd21);
        if (dones > 0) chk("t5_spacing", 64'(k - last_k), 64'd5);
        dones++;
        last_k = k;
      end
    end
    @(negedge clk); a.start = 0;
    chk("t5_dones", 64'(dones), 64'd4);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    a.start = 1; a.sgn = 0; a.x = 4'd5; a.y = 3'd6;
    @(posedge clk);
    @(negedge clk); a.start = 0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_p", 64'(a.p), 64'd0);
    chk("t6_busy", 64'(a.busy), 64'd0);
    chk("t6_done", 64'(a.done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (a.done) dones++;
    end
    chk("t6_no_done", 64'(dones), 64'd0);
    op_a(0, 9, 5, 1);
    chk("t6_45", 64'(a.p), 64'd45);

    // exhaustive 4x3, both modes
    for (int s = 0; s < 2; s++)
      for (int xv = 0; xv < 16; xv++)
        for (int yv = 0; yv < 8; yv++)
          op_a(1'(s), xv, yv, 0);

    // 8x8 corners then random
    op_b(1, 8'h80, 8'h80);
    chk("b_max_signed", 64'(b.p), 64'h4000);
    op_b(0, 8'hFF, 8'hFF);
    chk("b_max_unsigned", 64'(b.p), 64'hFE01);
    op_b(1, 8'h80, 8'h7F);
    op_b(0, 0, 8'hA5);
    for (int i = 0; i < 200; i++)
      op_b(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_mul_pm.md
Name: seq_mul_pm

Overview:
Parametrised sequential shift-add multiplier. It generalises the fixed 4x3 combinational multiplier (MUL43) to arbitrary operand widths. It adds an optional two's-complement mode and a START/BUSY/DONE handshake. It trades area for latency: one partial product per clock, and it feeds arithmetic datapaths that tolerate multi-cycle results.

Parameters:
XW, 4, width of multiplicand X (>=2)
YW, 3, width of multiplier Y (>=2); also the number of iteration cycles

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous, active-low reset
START  in  1  request; sampled only when not BUSY
SGN  in  1  sampled with START; 1 = X, Y and P are two's complement, 0 = unsigned
X  in  XW  multiplicand, sampled with START
Y  in  YW  multiplier, sampled with START
P  out  XW+YW  product, registered, held until overwritten
BUSY  out  1  high while an operation is in progress
DONE  out  1  one-cycle pulse when P is updated

Interface (already decided):
- One clock, CLK.
- Reset RST_N is asynchronous and active-low.

Behaviour:
- Reset (RST_N=0, any time, including mid-operation):
  - State IDLE; P=0, BUSY=0, DONE=0.
  - All internal registers cleared; any in-flight operation is discarded.
  - The first START is accepted on the first rising edge with RST_N=1.
- States: IDLE, CALC, FIN.
- IDLE:
  - BUSY=0.
  - On an edge with START=1, latch the operands and go to CALC.
  - Latching: xm = |X|, ym = |Y|, neg = SGN & (X[XW-1] ^ Y[YW-1]), acc = 0, cnt = 0.
  - Magnitudes are taken only when SGN=1; otherwise the raw values are used.
  - xm is XW bits unsigned; the most-negative input (e.g. -8 for XW=4) yields magnitude 8 with no overflow.
- CALC:
  - BUSY=1.
  - Each edge: if ym[0]=1 then acc += xm << cnt. Then ym >>= 1 and cnt += 1.
  - acc is XW+YW bits wide and is never truncated.
  - After YW iterations (cnt reaches YW), go to FIN.
- FIN:
  - BUSY=1.
  - On the next edge: P <= neg ? -acc : acc (two's-complement negate, XW+YW bits), DONE <= 1, state -> IDLE.
- DONE timing:
  - DONE is high for exactly one cycle, the cycle after the FIN edge.
  - DONE is low at all other times.
- Latency:
  - START sampled at edge n → P valid and DONE=1 from edge n+YW+1.
  - Throughput: one operation per YW+2 cycles.
- BUSY rises at edge n and falls at edge n+YW+1, coincident with DONE rising.
- Back-to-back operation:
  - START may be high during the DONE cycle (state is IDLE) and is accepted.
  - P keeps the previous result until the new FIN edge.
- START while BUSY=1 is ignored. Operands and SGN changing while busy have no effect.
- X or Y equal to 0 gives P=0 through full-length iteration; there is no early termination.
- The result is exact for every input in both modes:
  - Unsigned range: 0 .. (2^XW-1)(2^YW-1).
  - Signed maximum: (-2^(XW-1))(-2^(YW-1)) = 2^(XW+YW-2). This fits in XW+YW signed bits.

Test Plan:
1. Reset, then unsigned X=1111, Y=111, SGN=0, START one cycle → BUSY high 4 cycles; DONE pulse at edge n+4; P=1101001 (105).
2. Signed X=1000 (-8), Y=100 (-4), SGN=1 → P=0100000 (+32). Signed X=1111 (-1), Y=011 (3) → P=1111101 (-3). Signed X=0101 (5), Y=111 (-1) → P=1111011 (-5).
3. Unsigned X=0000, Y=101 → P=0000000 after full latency; a 1011×101 operation then gives P=0110111 (55).
4. Pulse START again while BUSY with different operands → ignored; P equals the first operation's result; exactly one DONE pulse.
5. Hold START high continuously with X=0111, Y=011 → an operation is accepted every 5 cycles; P=0010101 (21); DONE pulses are spaced 5 cycles apart.
6. Assert RST_N=0 mid-CALC, asynchronously between edges → P, BUSY and DONE go to 0 immediately with no DONE pulse; after release, a new X=1001, Y=101 unsigned → P=0101101 (45).
7. Exhaustive sweep, all X and Y in both modes for XW=4, YW=3, plus XW=8, YW=8 → every P matches the reference model product.
